sync_mod_counter: RTL
=====================

# sync_mod_counter

Fully synchronous, parametrised modulo counter: the next generation of the team's ripple counter. It has the same programmable modulus and auto/manual modes, plus up/down counting, parallel load, count enable, a registered terminal-count pulse and a divided-clock output. It is used as the general-purpose timer/divider in the counters library. Every flop sits on one clock, so it can be used inside synchronous datapaths and timed cleanly by STA.

## Interface
- CNT_WIDTH, 8, counter width in bits (≥2)
- clk  in  1  clock; all logic on posedge
- clr_n  in  1  asynchronous active-low reset
- en  in  1  count enable; the counter steps only when high
- up_dn  in  1  direction: 1 = up, 0 = down
- auto  in  1  1 = wrap and continue; 0 = stop at terminal (one-shot)
- sync_clr  in  1  synchronous clear to the start value
- load  in  1  synchronous parallel load
- load_val  in  CNT_WIDTH  value taken on load
- max_count  in  CNT_WIDTH  modulus M; 0 means 2^CNT_WIDTH
- count  out  CNT_WIDTH  current count (registered)
- count_n  out  CNT_WIDTH  ~count
- tc  out  1  terminal-count pulse, one cycle (registered)
- done  out  1  sticky; high while halted in one-shot mode
- div_out  out  1  toggles on each tc; output frequency = f(en steps)/(2M)

## Operation
- Start value: 0 when up_dn=1, M-1 when up_dn=0. This is used by sync_clr and by wrap.
- Terminal: up means count ≥ M-1; down means count == 0. The ≥ comparison covers loaded values ≥ M.
- FSM states: RUN, HALT. Reset leads to RUN.
- Priority each cycle: sync_clr > load > step.
  - sync_clr: count ← start value, state ← RUN, done ← 0, tc ← 0. div_out is unchanged.
  - load: count ← load_val (not clamped), state ← RUN, done ← 0. No tc.
- RUN with en=1 and not terminal: count ± 1.
- RUN with en=1 and terminal:
  - auto=1: count ← start value, tc ← 1 next cycle, div_out toggles. Stay in RUN.
  - auto=0: count holds, tc ← 1 next cycle, div_out toggles, done ← 1, go to HALT.
- HALT: count frozen and en ignored. Only sync_clr or load exits. Changing auto to 1 in HALT does not restart the counter.
- en=0: everything holds and tc is 0.
- M=1: count stays 0 and tc fires on every enabled cycle.
- M=0: full 2^CNT_WIDTH range with natural wrap.
- Changing up_dn mid-count takes effect on the next step from the current value. There is no implicit reload.
- Changing max_count mid-count is legal. The terminal test uses the live value.

## Timing
- Reset values (clr_n low, asynchronous): count=0, count_n=all ones, tc=0, done=0, div_out=0, state=RUN.
- Deassertion of clr_n is synchronised externally.
- Inputs are sampled on posedge clk. count reflects them one cycle later.
- tc is high for exactly one cycle, in the cycle after the terminal step. It is never high on two consecutive cycles unless M=1 with en held high.
- done rises together with tc in one-shot mode. It falls in the cycle after sync_clr or load.
- No combinational path from any input to any output.

## Structure
- Package counter_pkg holds:
  - typedef enum logic {CNT_RUN, CNT_HALT} cnt_state_t
  - localparam helpers for the M=0 full-range decode
- Single module plus one natural sub-module, mod_terminal_detect. It is purely combinational and produces the terminal flag and the start value from count, max_count and up_dn.

## Test plan
- CNT_WIDTH=4, M=7, up, auto=1, en high: count runs 0..6,0. tc pulses every 7 cycles. div_out has a period of 14 cycles.
- M=5, down, auto=1: count runs 4,3,2,1,0,4. tc appears in the cycle after 0→4.
- M=6, up, auto=0: count stops at 5. tc is one pulse and done=1. en stays high for 10 more cycles and count holds at 5. load with load_val=2 clears done and the count resumes at 3.
- load with load_val=9 when M=6, up: the next step goes to 0 and tc fires. Asserting sync_clr and load in the same cycle gives count=0.
- Edge moduli: M=1 gives count=0 with tc high while en=1. M=0 with CNT_WIDTH=4 wraps at 15→0. en toggling every other cycle halves the tc rate.
- Assert clr_n mid-count at 3 in HALT: all outputs are at reset values immediately, before the next clk edge. After release, counting restarts from 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counters library.
//   cnt_state_t      : run/halt state of the modulo counter
//   CNT_WIDTH_MIN    : smallest legal counter width
//   FULL_RANGE_CODE  : max_count value that selects the full 2^CNT_WIDTH modulus
package counter_pkg;

   typedef enum logic {
      CNT_RUN  = 1'b0,
      CNT_HALT = 1'b1
   } cnt_state_t;

   localparam int unsigned CNT_WIDTH_MIN = 2;

   // A modulus of 2^CNT_WIDTH cannot be written in CNT_WIDTH bits, so zero
   // stands in for it; the last value is then all ones.
   localparam int unsigned FULL_RANGE_CODE = 0;

endpackage : counter_pkg

// File: rtl/mod_terminal_detect.sv
// Combinational terminal decode for the modulo counter.
//   count       in  current count
//   max_count   in  modulus M (0 = 2^CNT_WIDTH)
//   up_dn       in  1 = counting up, 0 = counting down
//   terminal    out count is at the end of its range for this direction
//   start_value out value to restart from: 0 (up) or M-1 (down)
module mod_terminal_detect
   import counter_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic [CNT_WIDTH-1:0] count,
   input  logic [CNT_WIDTH-1:0] max_count,
   input  logic                 up_dn,
   output logic                 terminal,
   output logic [CNT_WIDTH-1:0] start_value
);

   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic                 full_range;
   logic [CNT_WIDTH-1:0] last_value;

   always_comb begin
      full_range = (max_count == CNT_WIDTH'(FULL_RANGE_CODE));
      last_value = full_range ? {CNT_WIDTH{1'b1}} : (max_count - ONE);
      // Greater-or-equal so a loaded value beyond M-1 still terminates
      // on its next up step instead of running to the natural wrap.
      terminal    = up_dn ? (count >= last_value) : (count == '0);
      start_value = up_dn ? '0 : last_value;
   end

endmodule : mod_terminal_detect

// File: rtl/sync_mod_counter.sv
// Fully synchronous programmable modulo counter (timer / divider).
//   clk        in  clock, posedge
//   clr_n      in  asynchronous active-low reset
//   en         in  count enable
//   up_dn      in  1 = up, 0 = down
//   auto       in  1 = wrap and continue, 0 = one-shot (halt at terminal)
//   sync_clr   in  synchronous clear to the start value (highest priority)
//   load       in  synchronous parallel load of load_val
//   load_val   in  value taken on load (not clamped to the modulus)
//   max_count  in  modulus M, 0 = 2^CNT_WIDTH
//   count      out registered count
//   count_n    out ~count
//   tc         out one-cycle registered terminal-count pulse
//   done       out sticky, high while halted in one-shot mode
//   div_out    out toggles on each terminal step
//   state      out run/halt state, for observation
module sync_mod_counter
   import counter_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 en,
   input  logic                 up_dn,
   input  logic                 auto,
   input  logic                 sync_clr,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_val,
   input  logic [CNT_WIDTH-1:0] max_count,
   output logic [CNT_WIDTH-1:0] count,
   output logic [CNT_WIDTH-1:0] count_n,
   output logic                 tc,
   output logic                 done,
   output logic                 div_out,
   output cnt_state_t           state
);

   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   if (CNT_WIDTH < CNT_WIDTH_MIN) begin : g_width_check
      $error("sync_mod_counter: CNT_WIDTH must be at least 2");
   end

   logic                 terminal;
   logic [CNT_WIDTH-1:0] start_value;

   mod_terminal_detect #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_detect (
      .count       (count),
      .max_count   (max_count),
      .up_dn       (up_dn),
      .terminal    (terminal),
      .start_value (start_value)
   );

   // count_n is a plain inversion of a flop, so no input reaches it
   // combinationally.
   assign count_n = ~count;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         count   <= '0;
         tc      <= 1'b0;
         done    <= 1'b0;
         div_out <= 1'b0;
         state   <= CNT_RUN;
      end else begin
         // tc is a single-cycle pulse: cleared unless a terminal step
         // happens this cycle.
         tc <= 1'b0;
         if (sync_clr) begin
            count <= start_value;
            done  <= 1'b0;
            state <= CNT_RUN;
         end else if (load) begin
            count <= load_val;
            done  <= 1'b0;
            state <= CNT_RUN;
         end else begin
            case (state)
               CNT_RUN: begin
                  if (en) begin
                     if (terminal) begin
                        tc      <= 1'b1;
                        div_out <= ~div_out;
                        if (auto) begin
                           count <= start_value;
                        end else begin
                           // One-shot: hold the terminal value and freeze.
                           done  <= 1'b1;
                           state <= CNT_HALT;
                        end
                     end else if (up_dn) begin
                        count <= count + ONE;
                     end else begin
                        count <= count - ONE;
                     end
                  end
               end
               CNT_HALT: begin
                  // Frozen until sync_clr or load; en and auto are ignored.
               end
               default: begin
                  state <= CNT_RUN;
               end
            endcase
         end
      end
   end

endmodule : sync_mod_counter
